pid_cfg_wr_master: RTL and testbench

- Host-side initiator of the per-channel configuration write bus (wr_en/wr_addr/wr_chan/wr_data) consumed by the PID filter and the other channelized pipeline blocks.
- Assembles 16-bit host words into complete write frames and issues single-cycle write strobes.
- Supports a broadcast channel code that replays one write across all N_CHAN channels.
- Sits between the host wire/pipe interface logic and every block on the config write bus.

---
 rtl/pid_cfg_wr_master_pkg.sv | 17 +
 rtl/pid_cfg_wr_master_host_word_shift.sv | 37 +++
 rtl/pid_cfg_wr_master.sv | 152 +++++++++++++++
 tb/tb_pid_cfg_wr_master.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_cfg_wr_master_pkg.sv
// Shared definitions for the config write master: frame word positions,
// the broadcast channel code and the FSM state encoding.
package pid_cfg_wr_master_pkg;

    localparam int FRM_ADDR = 0;
    localparam int FRM_CHAN = 1;
    localparam int FRM_D0   = 2;

    localparam logic [15:0] BCAST_CHAN = 16'hFFFF;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ISSUE   = 2'd1,
        BCAST   = 2'd2
    } state_t;

endpackage

// File: rtl/pid_cfg_wr_master_host_word_shift.sv
// Assembles the data field of a write frame from host words, most-significant
// word first. The final data word is taken live from the input, so the full
// data field is available in the same cycle that the last word is accepted.
module host_word_shift #(
    parameter int W_HOST   = 16,
    parameter int N_DWORDS = 3
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_shift_en,
    input  logic [W_HOST-1:0]            i_word,
    output logic [N_DWORDS*W_HOST-1:0]   o_data_next
);

    localparam int W_DATA = N_DWORDS * W_HOST;

    generate
        if (N_DWORDS > 1) begin : g_shift
            logic [W_DATA-W_HOST-1:0] r_hist;
            logic [W_DATA-1:0]        w_next;

            assign w_next      = {r_hist, i_word};
            assign o_data_next = w_next;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_hist <= '0;
                end else if (i_shift_en) begin
                    r_hist <= w_next[W_DATA-W_HOST-1:0];
                end
            end
        end else begin : g_single
            assign o_data_next = i_word;
        end
    endgenerate

endmodule

// File: rtl/pid_cfg_wr_master.sv
// Host-side initiator of the per-channel config write bus: collects frames of
// host words and issues single-cycle write strobes, optionally to all channels.
module pid_cfg_wr_master #(
    parameter int                   N_CHAN     = 8,
    parameter int                   W_HOST     = 16,
    parameter int                   W_WR_ADDR  = 16,
    parameter int                   W_WR_CHAN  = 16,
    parameter int                   W_WR_DATA  = 48,
    parameter logic [W_WR_CHAN-1:0] BCAST_CHAN = W_WR_CHAN'(pid_cfg_wr_master_pkg::BCAST_CHAN)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  host_dv_in,
    input  logic [W_HOST-1:0]     host_word_in,
    input  logic                  host_sync_in,
    output logic                  host_rdy_out,
    output logic                  wr_en,
    output logic [W_WR_ADDR-1:0]  wr_addr,
    output logic [W_WR_CHAN-1:0]  wr_chan,
    output logic [W_WR_DATA-1:0]  wr_data,
    output logic                  busy_out,
    output logic [7:0]            err_cnt_out
);

    import pid_cfg_wr_master_pkg::*;

    localparam int N_DWORDS = W_WR_DATA / W_HOST;
    localparam int N_FRAME  = N_DWORDS + 2;
    localparam int W_IDX    = $clog2(N_FRAME);
    localparam int W_BCNT   = $clog2(N_CHAN) + 1;

    state_t                 r_state;
    logic [W_IDX-1:0]       r_idx;
    logic [W_WR_ADDR-1:0]   r_addr;
    logic [W_WR_CHAN-1:0]   r_chan;
    logic [W_BCNT-1:0]      r_bcnt;
    logic [7:0]             r_err;
    logic                   r_rdy;
    logic                   r_busy;
    logic                   r_wr_en;
    logic [W_WR_ADDR-1:0]   r_wr_addr;
    logic [W_WR_CHAN-1:0]   r_wr_chan;
    logic [W_WR_DATA-1:0]   r_wr_data;

    logic                   w_accept;
    logic                   w_last;
    logic                   w_shift_en;
    logic                   w_chan_ok;
    logic                   w_chan_bc;
    logic [7:0]             w_err_inc;
    logic [W_WR_DATA-1:0]   w_frame_data;

    // Sync outranks a word offered in the same cycle.
    assign w_accept   = (r_state == COLLECT) && host_dv_in && !host_sync_in;
    assign w_last     = (r_idx == W_IDX'(N_FRAME - 1));
    assign w_shift_en = w_accept && (r_idx >= W_IDX'(FRM_D0));
    assign w_chan_ok  = (r_chan < W_WR_CHAN'(N_CHAN));
    assign w_chan_bc  = (r_chan == BCAST_CHAN);
    assign w_err_inc  = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

    host_word_shift #(
        .W_HOST   (W_HOST),
        .N_DWORDS (N_DWORDS)
    ) u_shift (
        .i_clk       (clk_in),
        .i_rst       (rst_in),
        .i_shift_en  (w_shift_en),
        .i_word      (host_word_in),
        .o_data_next (w_frame_data)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= COLLECT;
            r_idx     <= '0;
            r_addr    <= '0;
            r_chan    <= '0;
            r_bcnt    <= '0;
            r_err     <= '0;
            r_rdy     <= 1'b1;
            r_busy    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_chan <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                COLLECT: begin
                    if (host_sync_in) begin
                        if (r_idx != '0) begin
                            r_idx <= '0;
                            r_err <= w_err_inc;
                        end
                    end else if (w_accept) begin
                        if (r_idx == W_IDX'(FRM_ADDR)) r_addr <= host_word_in[W_WR_ADDR-1:0];
                        if (r_idx == W_IDX'(FRM_CHAN)) r_chan <= host_word_in[W_WR_CHAN-1:0];
                        if (w_last) begin
                            r_idx <= '0;
                            if (w_chan_ok || w_chan_bc) begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_addr;
                                r_wr_chan <= w_chan_ok ? r_chan : '0;
                                r_wr_data <= w_frame_data;
                                r_bcnt    <= '0;
                                r_state   <= w_chan_ok ? ISSUE : BCAST;
                                r_rdy     <= 1'b0;
                                r_busy    <= 1'b1;
                            end else begin
                                r_err <= w_err_inc;
                            end
                        end else begin
                            r_idx <= r_idx + W_IDX'(1);
                        end
                    end
                end
                ISSUE: begin
                    r_state <= COLLECT;
                    r_rdy   <= 1'b1;
                    r_busy  <= 1'b0;
                end
                BCAST: begin
                    // The strobe already on the bus completes; sync only stops the rest.
                    if (host_sync_in || (r_bcnt == W_BCNT'(N_CHAN - 1))) begin
                        r_state <= COLLECT;
                        r_rdy   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_bcnt    <= r_bcnt + W_BCNT'(1);
                        r_wr_en   <= 1'b1;
                        r_wr_chan <= W_WR_CHAN'(r_bcnt + W_BCNT'(1));
                    end
                end
                default: begin
                    r_state <= COLLECT;
                    r_idx   <= '0;
                    r_rdy   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign host_rdy_out = r_rdy;
    assign busy_out     = r_busy;
    assign err_cnt_out  = r_err;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_chan      = r_wr_chan;
    assign wr_data      = r_wr_data;

endmodule

// File: tb/tb_pid_cfg_wr_master.sv
// Directed and randomized checks of pid_cfg_wr_master against a frame-level
// reference model (expected write list and saturating error count).
module tb_pid_cfg_wr_master;

    localparam int N_CHAN = 8;

    logic        clk_in       = 1'b0;
    logic        rst_in       = 1'b1;
    logic        host_dv_in   = 1'b0;
    logic [15:0] host_word_in = 16'h0;
    logic        host_sync_in = 1'b0;
    logic        host_rdy_out;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_chan;
    logic [47:0] wr_data;
    logic        busy_out;
    logic [7:0]  err_cnt_out;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_err  = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] c;
        logic [47:0] d;
        int          off;
    } wr_t;

    wr_t obs[$];
    int  n_rdy_low;
    int  n_busy;

    pid_cfg_wr_master #(
        .N_CHAN    (N_CHAN),
        .W_HOST    (16),
        .W_WR_ADDR (16),
        .W_WR_CHAN (16),
        .W_WR_DATA (48),
        .BCAST_CHAN(16'hFFFF)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .host_dv_in   (host_dv_in),
        .host_word_in (host_word_in),
        .host_sync_in (host_sync_in),
        .host_rdy_out (host_rdy_out),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_chan      (wr_chan),
        .wr_data      (wr_data),
        .busy_out     (busy_out),
        .err_cnt_out  (err_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int exp_nwr(input logic [15:0] c);
        if (int'(c) < N_CHAN) return 1;
        if (c == 16'hFFFF)    return N_CHAN;
        return 0;
    endfunction

    function automatic int sat_inc(input int e);
        return (e >= 255) ? 255 : e + 1;
    endfunction

    // Called at a falling edge; holds the word until a rising edge sees ready.
    task automatic send_word(input logic [15:0] w);
        int n = 0;
        host_dv_in   = 1'b1;
        host_word_in = w;
        while (host_rdy_out !== 1'b1 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 100) chk("rdy_timeout", 64'(host_rdy_out), 64'd1);
        @(negedge clk_in);
        host_dv_in = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] c, input logic [47:0] d);
        send_word(a);
        send_word(c);
        send_word(d[47:32]);
        send_word(d[31:16]);
        send_word(d[15:0]);
    endtask

    task automatic capture(input int ncyc, input int sync_at, input int offer_n);
        wr_t t;
        obs.delete();
        n_rdy_low = 0;
        n_busy    = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) @(negedge clk_in);
            if (wr_en === 1'b1) begin
                t.a = wr_addr; t.c = wr_chan; t.d = wr_data; t.off = k;
                obs.push_back(t);
            end
            if (host_rdy_out !== 1'b1) n_rdy_low++;
            if (busy_out === 1'b1)     n_busy++;
            host_sync_in = (k == sync_at);
            if (offer_n > 0) host_dv_in = (k < offer_n);
        end
        host_sync_in = 1'b0;
        host_dv_in   = 1'b0;
    endtask

    task automatic check_writes(input string tag, input logic [15:0] a, input logic [47:0] d,
                                input int first_chan, input int n);
        int m;
        chk({tag, "_nwr"}, 64'(obs.size()), 64'(n));
        m = (obs.size() < n) ? obs.size() : n;
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_chan%0d", tag, i), 64'(obs[i].c), 64'(first_chan + i));
            chk($sformatf("%s_addr%0d", tag, i), 64'(obs[i].a), 64'(a));
            chk($sformatf("%s_data%0d", tag, i), 64'(obs[i].d), 64'(d));
            chk($sformatf("%s_off%0d",  tag, i), 64'(obs[i].off), 64'(i));
        end
    endtask

    task automatic run_frame(input string tag, input logic [15:0] a, input logic [15:0] c,
                             input logic [47:0] d, input int offer_n);
        int n;
        send_frame(a, c, d);
        capture(12, -1, offer_n);
        n = exp_nwr(c);
        if (n == 0) exp_err = sat_inc(exp_err);
        check_writes(tag, a, d, (int'(c) < N_CHAN) ? int'(c) : 0, n);
        chk({tag, "_rdy_low"}, 64'(n_rdy_low), 64'(n));
        chk({tag, "_busy"},    64'(n_busy),    64'(n));
        chk({tag, "_err"},     64'(err_cnt_out), 64'(exp_err));
    endtask

    initial begin
        logic [15:0] ra, rc;
        logic [47:0] rd;
        int          sel;

        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("reset_rdy",   64'(host_rdy_out), 64'd1);
        chk("reset_wr_en", 64'(wr_en),        64'd0);
        chk("reset_busy",  64'(busy_out),     64'd0);
        chk("reset_err",   64'(err_cnt_out),  64'd0);
        chk("reset_addr",  64'(wr_addr),      64'd0);
        chk("reset_chan",  64'(wr_chan),      64'd0);
        chk("reset_data",  64'(wr_data),      64'd0);

        run_frame("single", 16'h0003, 16'h0002, 48'h0000_0001_2345, 0);

        // Words offered during the broadcast must be refused.
        host_word_in = 16'hAAAA;
        run_frame("bcast", 16'h0005, 16'hFFFF, 48'h0000_0000_0010, 7);
        run_frame("after_bcast", 16'h0011, 16'h0007, 48'hDEAD_BEEF_0001, 0);

        run_frame("invalid", 16'h0020, 16'h0009, 48'h1111_2222_3333, 0);
        run_frame("after_inv", 16'h0021, 16'h0004, 48'h4444_5555_6666, 0);
        chk("held_addr", 64'(wr_addr), 64'h0021);
        chk("held_chan", 64'(wr_chan), 64'h0004);

        send_word(16'h0030);
        send_word(16'h0001);
        send_word(16'h7777);
        host_sync_in = 1'b1;
        host_dv_in   = 1'b1;
        host_word_in = 16'h5555;
        @(negedge clk_in);
        host_sync_in = 1'b0;
        host_dv_in   = 1'b0;
        exp_err = sat_inc(exp_err);
        chk("abort_err", 64'(err_cnt_out), 64'(exp_err));
        run_frame("after_abort", 16'h0031, 16'h0006, 48'h0102_0304_0506, 0);

        host_sync_in = 1'b1;
        @(negedge clk_in);
        host_sync_in = 1'b0;
        @(negedge clk_in);
        chk("idle_sync_err", 64'(err_cnt_out), 64'(exp_err));

        send_frame(16'h0040, 16'hFFFF, 48'hCAFE_0000_0042);
        capture(12, 2, 0);
        check_writes("bc_sync", 16'h0040, 48'hCAFE_0000_0042, 0, 3);
        chk("bc_sync_rdy_low", 64'(n_rdy_low), 64'd3);
        chk("bc_sync_busy",    64'(n_busy),    64'd3);
        chk("bc_sync_err",     64'(err_cnt_out), 64'(exp_err));
        run_frame("after_bc_sync", 16'h0041, 16'h0000, 48'h0000_0000_0001, 0);

        send_frame(16'h0077, 16'hFFFF, 48'h0A0B_0C0D_0E0F);
        repeat (3) @(negedge clk_in);
        chk("rst_pre_en",   64'(wr_en),   64'd1);
        chk("rst_pre_chan", 64'(wr_chan), 64'd3);
        #2;
        rst_in       = 1'b1;
        host_dv_in   = 1'b1;
        host_word_in = 16'h1234;
        #1;
        chk("rst_async_en",   64'(wr_en),       64'd0);
        chk("rst_async_chan", 64'(wr_chan),     64'd0);
        chk("rst_async_err",  64'(err_cnt_out), 64'd0);
        chk("rst_async_busy", 64'(busy_out),    64'd0);
        exp_err = 0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in     = 1'b0;
        host_dv_in = 1'b0;
        @(negedge clk_in);
        chk("rst_rel_rdy", 64'(host_rdy_out), 64'd1);
        run_frame("after_rst", 16'h0078, 16'h0005, 48'h9999_8888_7777, 0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            ra  = 16'($urandom);
            rd  = {16'($urandom), 32'($urandom)};
            if (sel < 2)       rc = 16'($urandom_range(0, N_CHAN - 1));
            else if (sel == 2) rc = 16'hFFFF;
            else               rc = 16'($urandom_range(N_CHAN, 16'hFFFE));
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
            run_frame($sformatf("rnd%0d", i), ra, rc, rd, 0);
        end

        for (int i = 0; i < 260; i++) begin
            send_frame(16'(i), 16'($urandom_range(N_CHAN, 16'hFFFE)), 48'(i));
            exp_err = sat_inc(exp_err);
            if (i == 100) chk("sat_mid", 64'(err_cnt_out), 64'(exp_err));
        end
        @(negedge clk_in);
        chk("sat_model", 64'(err_cnt_out), 64'(exp_err));
        chk("sat_255",   64'(err_cnt_out), 64'd255);
        run_frame("after_sat", 16'h00AB, 16'h0001, 48'h0000_1234_5678, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
